axis_frame_streamer: RTL and testbench
======================================

Name: axis_frame_streamer

Overview:
- Upstream source stage of every pattern generator in the video path; the gradient generator is one consumer.
- Produces the raster scan for one or more frames as an AXI4-Stream master, with TUSER marking start-of-frame and TLAST marking end-of-line.
- Exposes the (x, y) coordinate of the beat currently presented, so a downstream combinational pattern function can compute pixel colour for that beat.
- Contains the frame state machine, inter-frame gap timer and frame counter. Carries no pixel data itself.

Parameters:
- H_RES, 1024: active pixels per line; legal range 1..4096.
- V_RES, 768: active lines per frame; legal range 1..4096.
- DATA_WIDTH, 16: TDATA width of m_axis.
- USER_WIDTH, 1: TUSER width of m_axis; minimum 1.
- ID_WIDTH, 0: TID width; TID is driven to zero.
- DEST_WIDTH, 0: TDEST width; TDEST is driven to zero.
- FRAME_GAP, 0: idle cycles inserted after each frame before the next one starts; 0 means back-to-back frames.
- COORD_WIDTH, 12: width of x_o and y_o.

Ports:
- clk_i, input, 1: clock. All logic is in this single clock domain.
- rst_ni, input, 1: reset. Asynchronous, active-low.
- en_i, input, 1: run enable. Sampled only at frame boundaries.
- x_o, output, COORD_WIDTH: column of the current beat, 0..H_RES-1.
- y_o, output, COORD_WIDTH: line of the current beat, 0..V_RES-1.
- frame_done_o, output, 1: one-cycle pulse on acceptance of the last beat of a frame.
- frame_cnt_o, output, 16: number of completed frames; wraps modulo 2^16.
- busy_o, output, 1: high whenever the state is not IDLE.
- m_axis, axi4s_if.master, n/a: output stream carrying TVALID, TREADY, TDATA, TLAST, TUSER, TID and TDEST.

Behaviour:
- Reset: all outputs are driven low or zero, the state is IDLE, and the counters are cleared. Reset asserted mid-frame aborts the frame immediately with no completion pulse. After reset release the next frame starts at (0,0) with TUSER set.
- Beat acceptance: a beat is accepted in any cycle where TVALID and TREADY are both high.
- Field encoding:
  - TDATA is always '0. Colour comes from the downstream pattern stage.
  - TUSER[0] is high only when x=0 and y=0. Upper TUSER bits are 0.
  - TLAST is high only when x=H_RES-1.
- Stability rule: while TVALID is high and TREADY is low, TUSER, TLAST, x_o and y_o hold their values. TVALID never drops without an acceptance.
- Output timing: all stream signals and the coordinates are registered. The coordinates are aligned with the beat being presented, with no skew.
- State IDLE:
  - TVALID = 0.
  - If en_i = 1, go to ACTIVE on the next edge with x = y = 0.
- State ACTIVE:
  - TVALID = 1.
  - On each acceptance, x increments. When x = H_RES-1, x wraps to 0 and y increments.
  - Acceptance at (H_RES-1, V_RES-1) is the end of frame:
    - frame_done_o pulses in the next cycle.
    - frame_cnt_o increments.
    - x and y both return to 0.
    - Next state is GAP if FRAME_GAP > 0. Otherwise next state is ACTIVE if en_i = 1, or IDLE if en_i = 0.
  - Back-to-back frames: the first beat of the next frame is valid in the cycle after the last acceptance, so there is no bubble.
- State GAP:
  - TVALID = 0.
  - A down-counter runs FRAME_GAP cycles.
  - On expiry: go to ACTIVE if en_i = 1, else IDLE.
- en_i deasserted mid-frame: the current frame always completes; frames are never truncated. en_i is re-evaluated only at the end of frame or gap expiry.
- H_RES=1: every beat has TLAST set, and x stays at 0.
- V_RES=1: the end of line is also the end of frame.
- H_RES=1 and V_RES=1: every beat carries both TUSER and TLAST.
- Counter widths:
  - x and y counters are COORD_WIDTH bits.
  - The gap counter is $clog2(FRAME_GAP+1) bits, minimum 1.
- busy_o is high in ACTIVE and GAP.

Test Plan:
1. H_RES=4, V_RES=3, FRAME_GAP=0, TREADY=1, en_i held at 1 -> 12 beats per frame; TUSER on beat 0 only; TLAST on beats 3, 7 and 11; x_o/y_o follow (0,0)..(3,2); frame_done_o pulses once per 12 beats; no bubbles between frames.
2. Same configuration, TREADY toggled pseudo-randomly -> no beat lost or duplicated; x_o, y_o, TUSER and TLAST stable during stalls; still exactly 12 beats per frame.
3. FRAME_GAP=5, en_i=1 -> exactly 5 cycles with TVALID=0 between the last beat of one frame and the TUSER beat of the next; busy_o stays 1 through the gap.
4. en_i dropped at beat 5 of frame 0 -> beats 6..11 are still emitted; state then goes to IDLE; frame_cnt_o = 1; TVALID stays low until en_i returns, then the next frame starts at (0,0) with TUSER set.
5. rst_ni asserted at beat 7 while TREADY=0 -> TVALID drops immediately, with no frame_done_o and frame_cnt_o = 0; after release with en_i=1 the next frame starts at (0,0) with TUSER set.
6. H_RES=1, V_RES=1 -> every beat has TUSER=1 and TLAST=1; frame_cnt_o increments on every acceptance and wraps from 65535 to 0.

Source files
------------

// File: rtl/axis_frame_streamer_if.sv
// AXI4-Stream bundle shared between the frame streamer and its consumers.
// Zero-width TID/TDEST collapse to a single bit that the master ties to zero.
interface axi4s_if #(
   parameter int DATA_WIDTH = 16,
   parameter int USER_WIDTH = 1,
   parameter int ID_WIDTH   = 0,
   parameter int DEST_WIDTH = 0
);
   localparam int IdW   = (ID_WIDTH   > 0) ? ID_WIDTH   : 1;
   localparam int DestW = (DEST_WIDTH > 0) ? DEST_WIDTH : 1;

   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tlast;
   logic [USER_WIDTH-1:0] tuser;
   logic [IdW-1:0]        tid;
   logic [DestW-1:0]      tdest;

   modport master (output tvalid, tdata, tlast, tuser, tid, tdest, input tready);
   modport slave  (input tvalid, tdata, tlast, tuser, tid, tdest, output tready);
endinterface

// File: rtl/axis_frame_streamer.sv
// Raster-scan source for the pattern generators: walks (x, y) over each frame,
// flags start-of-frame on TUSER and end-of-line on TLAST, and counts frames.
module axis_frame_streamer #(
   parameter int H_RES       = 1024,
   parameter int V_RES       = 768,
   parameter int DATA_WIDTH  = 16,
   parameter int USER_WIDTH  = 1,
   parameter int ID_WIDTH    = 0,
   parameter int DEST_WIDTH  = 0,
   parameter int FRAME_GAP   = 0,
   parameter int COORD_WIDTH = 12
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   en_i,
   output logic [COORD_WIDTH-1:0] x_o,
   output logic [COORD_WIDTH-1:0] y_o,
   output logic                   frame_done_o,
   output logic [15:0]            frame_cnt_o,
   output logic                   busy_o,
   axi4s_if.master                m_axis
);
   localparam int GapW = (FRAME_GAP > 0) ? $clog2(FRAME_GAP + 1) : 1;
   localparam logic [COORD_WIDTH-1:0] XLast   = COORD_WIDTH'(H_RES - 1);
   localparam logic [COORD_WIDTH-1:0] YLast   = COORD_WIDTH'(V_RES - 1);
   localparam logic [GapW-1:0]        GapLoad = GapW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

   typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

   state_t                 state_q, state_d;
   logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
   logic [GapW-1:0]        gap_q, gap_d;
   logic [15:0]            cnt_q, cnt_d;
   logic                   done_q, done_d;
   logic                   tvalid_q, tvalid_d;
   logic                   tuser_q, tuser_d;
   logic                   tlast_q, tlast_d;
   logic                   accept;

   assign accept = tvalid_q & m_axis.tready;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         gap_q    <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         tvalid_q <= 1'b0;
         tuser_q  <= 1'b0;
         tlast_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         gap_q    <= gap_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         tvalid_q <= tvalid_d;
         tuser_q  <= tuser_d;
         tlast_q  <= tlast_d;
      end
   end

   // Stream flags are derived from the next coordinates so they leave the
   // flops already aligned with the beat they describe.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      gap_d   = gap_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (en_i) begin
               state_d = ACTIVE;
               x_d     = '0;
               y_d     = '0;
            end
         end
         ACTIVE: begin
            if (accept) begin
               if (x_q == XLast) begin
                  x_d = '0;
                  if (y_q == YLast) begin
                     y_d    = '0;
                     done_d = 1'b1;
                     cnt_d  = cnt_q + 16'd1;
                     if (FRAME_GAP > 0) begin
                        state_d = GAP;
                        gap_d   = GapLoad;
                     end else begin
                        state_d = en_i ? ACTIVE : IDLE;
                     end
                  end else begin
                     y_d = y_q + 1'b1;
                  end
               end else begin
                  x_d = x_q + 1'b1;
               end
            end
         end
         GAP: begin
            if (gap_q == '0) begin
               state_d = en_i ? ACTIVE : IDLE;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      tvalid_d = (state_d == ACTIVE);
      tuser_d  = tvalid_d && (x_d == '0) && (y_d == '0);
      tlast_d  = tvalid_d && (x_d == XLast);
   end

   assign x_o          = x_q;
   assign y_o          = y_q;
   assign frame_done_o = done_q;
   assign frame_cnt_o  = cnt_q;
   assign busy_o       = (state_q != IDLE);

   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tdata  = '0;
   assign m_axis.tlast  = tlast_q;
   assign m_axis.tuser  = USER_WIDTH'(tuser_q);
   assign m_axis.tid    = '0;
   assign m_axis.tdest  = '0;
endmodule

// File: tb/tb_axis_frame_streamer.sv
// Directed bench for axis_frame_streamer: a 4x3 raster with and without an
// inter-frame gap, plus a 1x1 raster used to exercise the frame counter wrap.
module tb_axis_frame_streamer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a = 1'b0, en_a = 1'b0;
   logic rst_g = 1'b0, en_g = 1'b0;
   logic rst_1 = 1'b0, en_1 = 1'b0;

   logic [11:0] x_a, y_a, x_g, y_g, x_1, y_1;
   logic        done_a, done_g, done_1, busy_a, busy_g, busy_1;
   logic [15:0] cnt_a, cnt_g, cnt_1;

   axi4s_if #(.DATA_WIDTH(16), .USER_WIDTH(1), .ID_WIDTH(0), .DEST_WIDTH(0)) if_a ();
   axi4s_if #(.DATA_WIDTH(16), .USER_WIDTH(1), .ID_WIDTH(0), .DEST_WIDTH(0)) if_g ();
   axi4s_if #(.DATA_WIDTH(16), .USER_WIDTH(1), .ID_WIDTH(0), .DEST_WIDTH(0)) if_1 ();

   axis_frame_streamer #(.H_RES(4), .V_RES(3), .FRAME_GAP(0)) dut_a (
      .clk_i(clk), .rst_ni(rst_a), .en_i(en_a), .x_o(x_a), .y_o(y_a),
      .frame_done_o(done_a), .frame_cnt_o(cnt_a), .busy_o(busy_a), .m_axis(if_a));

   axis_frame_streamer #(.H_RES(4), .V_RES(3), .FRAME_GAP(5)) dut_g (
      .clk_i(clk), .rst_ni(rst_g), .en_i(en_g), .x_o(x_g), .y_o(y_g),
      .frame_done_o(done_g), .frame_cnt_o(cnt_g), .busy_o(busy_g), .m_axis(if_g));

   axis_frame_streamer #(.H_RES(1), .V_RES(1), .FRAME_GAP(0)) dut_1 (
      .clk_i(clk), .rst_ni(rst_1), .en_i(en_1), .x_o(x_1), .y_o(y_1),
      .frame_done_o(done_1), .frame_cnt_o(cnt_1), .busy_o(busy_1), .m_axis(if_1));

   typedef struct {
      logic        rdy;
      logic        en;
      logic        valid;
      logic        user;
      logic        last;
      logic [11:0] x;
      logic [11:0] y;
      logic        done;
      logic [15:0] cnt;
      logic        busy;
   } vec_t;

   vec_t vecs[15];
   int   checks_total  = 0;
   int   checks_passed = 0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic applyStimulus(input logic rdy, input logic en);
      if_a.tready = rdy;
      en_a        = en;
   endtask

   task automatic resetA();
      rst_a = 1'b0;
      applyStimulus(1'b1, 1'b0);
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
   endtask

   initial begin
      int b;
      logic prev_end;
      logic rdy;

      if_a.tready = 1'b1;
      if_g.tready = 1'b1;
      if_1.tready = 1'b1;

      // Hand-computed beats of a 4x3 raster at full throughput, one per cycle.
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0, 16'd0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 16'd0, 1'b1};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd1, 12'd0, 1'b0, 16'd0, 1'b1};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd2, 12'd0, 1'b0, 16'd0, 1'b1};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'd3, 12'd0, 1'b0, 16'd0, 1'b1};
      vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 12'd1, 1'b0, 16'd0, 1'b1};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd1, 12'd1, 1'b0, 16'd0, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd2, 12'd1, 1'b0, 16'd0, 1'b1};
      vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'd3, 12'd1, 1'b0, 16'd0, 1'b1};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 12'd2, 1'b0, 16'd0, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd1, 12'd2, 1'b0, 16'd0, 1'b1};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd2, 12'd2, 1'b0, 16'd0, 1'b1};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 12'd3, 12'd2, 1'b0, 16'd0, 1'b1};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b1, 16'd1, 1'b1};
      vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd1, 12'd0, 1'b0, 16'd1, 1'b1};

      // Reset state
      @(negedge clk); #1;
      checkOutput("rst_valid", 32'(if_a.tvalid), 0);
      checkOutput("rst_user",  32'(if_a.tuser), 0);
      checkOutput("rst_last",  32'(if_a.tlast), 0);
      checkOutput("rst_x",     32'(x_a), 0);
      checkOutput("rst_y",     32'(y_a), 0);
      checkOutput("rst_done",  32'(done_a), 0);
      checkOutput("rst_cnt",   32'(cnt_a), 0);
      checkOutput("rst_busy",  32'(busy_a), 0);

      // Full-rate 4x3 frames from the table
      resetA();
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i].rdy, vecs[i].en);
         #1;
         checkOutput($sformatf("t1_valid[%0d]", i), 32'(if_a.tvalid), 32'(vecs[i].valid));
         checkOutput($sformatf("t1_user[%0d]", i),  32'(if_a.tuser), 32'(vecs[i].user));
         checkOutput($sformatf("t1_last[%0d]", i),  32'(if_a.tlast), 32'(vecs[i].last));
         checkOutput($sformatf("t1_x[%0d]", i),     32'(x_a), 32'(vecs[i].x));
         checkOutput($sformatf("t1_y[%0d]", i),     32'(y_a), 32'(vecs[i].y));
         checkOutput($sformatf("t1_done[%0d]", i),  32'(done_a), 32'(vecs[i].done));
         checkOutput($sformatf("t1_cnt[%0d]", i),   32'(cnt_a), 32'(vecs[i].cnt));
         checkOutput($sformatf("t1_busy[%0d]", i),  32'(busy_a), 32'(vecs[i].busy));
         checkOutput($sformatf("t1_data[%0d]", i),  32'(if_a.tdata), 0);
      end

      // Random backpressure: a beat index model tracks what must be presented
      b = 14;
      prev_end = 1'b0;
      for (int c = 0; c < 96; c++) begin
         @(negedge clk);
         rdy = 1'($urandom_range(0, 1));
         applyStimulus(rdy, 1'b1);
         #1;
         checkOutput("t2_valid", 32'(if_a.tvalid), 1);
         checkOutput("t2_x",     32'(x_a), 32'(b % 4));
         checkOutput("t2_y",     32'(y_a), 32'((b / 4) % 3));
         checkOutput("t2_user",  32'(if_a.tuser), 32'(b % 12 == 0));
         checkOutput("t2_last",  32'(if_a.tlast), 32'(b % 4 == 3));
         checkOutput("t2_done",  32'(done_a), 32'(prev_end));
         checkOutput("t2_cnt",   32'(cnt_a), 32'(b / 12));
         if (rdy) begin
            prev_end = (b % 12 == 11);
            b++;
         end else begin
            prev_end = 1'b0;
         end
      end

      // Five idle cycles between frames, busy held through the gap
      rst_g = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         en_g = 1'b1;
         #1;
         checkOutput($sformatf("t3_valid[%0d]", c), 32'(if_g.tvalid),
                     32'((c >= 1 && c <= 12) || c >= 18));
         checkOutput($sformatf("t3_busy[%0d]", c), 32'(busy_g), 32'(c >= 1));
         checkOutput($sformatf("t3_done[%0d]", c), 32'(done_g), 32'(c == 13));
         checkOutput($sformatf("t3_user[%0d]", c), 32'(if_g.tuser), 32'(c == 1 || c == 18));
      end

      // en_i dropped mid-frame: frame completes, then IDLE until re-enabled
      resetA();
      for (int c = 0; c < 19; c++) begin
         @(negedge clk);
         applyStimulus(1'b1, !(c >= 6 && c <= 16));
         #1;
         checkOutput($sformatf("t4_valid[%0d]", c), 32'(if_a.tvalid),
                     32'((c >= 1 && c <= 12) || c >= 18));
         checkOutput($sformatf("t4_done[%0d]", c), 32'(done_a), 32'(c == 13));
         if (c == 7) begin
            checkOutput("t4_x7", 32'(x_a), 2);
            checkOutput("t4_y7", 32'(y_a), 1);
         end
         if (c == 12) checkOutput("t4_last12", 32'(if_a.tlast), 1);
         if (c == 14) checkOutput("t4_busy14", 32'(busy_a), 0);
         if (c == 17) checkOutput("t4_cnt17", 32'(cnt_a), 1);
         if (c == 18) begin
            checkOutput("t4_user18", 32'(if_a.tuser), 1);
            checkOutput("t4_x18",    32'(x_a), 0);
            checkOutput("t4_y18",    32'(y_a), 0);
         end
      end

      // Reset during a stalled beat aborts the frame with no completion
      resetA();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         applyStimulus(1'b1, 1'b1);
      end
      @(negedge clk);
      applyStimulus(1'b0, 1'b1);
      #1;
      checkOutput("t5_valid_stall", 32'(if_a.tvalid), 1);
      checkOutput("t5_x_stall",     32'(x_a), 3);
      checkOutput("t5_y_stall",     32'(y_a), 1);
      rst_a = 1'b0;
      #1;
      checkOutput("t5_valid_rst", 32'(if_a.tvalid), 0);
      checkOutput("t5_done_rst",  32'(done_a), 0);
      checkOutput("t5_cnt_rst",   32'(cnt_a), 0);
      checkOutput("t5_busy_rst",  32'(busy_a), 0);
      repeat (2) @(negedge clk);
      rst_a = 1'b1;
      applyStimulus(1'b1, 1'b1);
      @(negedge clk); #1;
      checkOutput("t5_valid_post", 32'(if_a.tvalid), 1);
      checkOutput("t5_user_post",  32'(if_a.tuser), 1);
      checkOutput("t5_x_post",     32'(x_a), 0);
      checkOutput("t5_y_post",     32'(y_a), 0);
      checkOutput("t5_cnt_post",   32'(cnt_a), 0);

      // 1x1 raster: every beat is SOF and EOL; frame counter wraps
      @(negedge clk);
      rst_1 = 1'b1;
      en_1  = 1'b1;
      for (int k = 1; k <= 65537; k++) begin
         @(negedge clk); #1;
         if (k <= 4) begin
            checkOutput($sformatf("t6_user[%0d]", k), 32'(if_1.tuser), 1);
            checkOutput($sformatf("t6_last[%0d]", k), 32'(if_1.tlast), 1);
            checkOutput($sformatf("t6_x[%0d]", k),    32'(x_1), 0);
            checkOutput($sformatf("t6_cnt[%0d]", k),  32'(cnt_1), 32'(k - 1));
            checkOutput($sformatf("t6_done[%0d]", k), 32'(done_1), 32'(k >= 2));
         end
         if (k == 65536) checkOutput("t6_cnt_max",  32'(cnt_1), 65535);
         if (k == 65537) begin
            checkOutput("t6_cnt_wrap",  32'(cnt_1), 0);
            checkOutput("t6_done_wrap", 32'(done_1), 1);
         end
      end

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end
endmodule
